// File: rtl/ir_cmd_decoder.sv
// ir_cmd_decoder: NEC IR frame to one-hot motor command with validation, dead-man timeout and update channel
// Ports: clk, rst (sync, active-high); data_ready/ir_data from IR receiver;
//   cmd (one-hot), motor_stat (encoded); upd_valid/upd_ready/upd_byte status handshake;
//   err_count (saturating rejected-frame count).
// Option: define IR_ADDR_CHECK_EN to also require ir_data[15:0] == ADDR.
module ir_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 12_500_000,
  parameter logic [15:0] ADDR = 16'h7F80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ready,
  input  logic [31:0] ir_data,
  output logic [7:0]  cmd,
  output logic [2:0]  motor_stat,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [7:0]  upd_byte,
  output logic [7:0]  err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
`ifdef IR_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_state_nxt;
  logic r_dr_q, r_chk_q, r_upd_valid;
  logic [31:0] r_frame_q;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0] r_cmd, w_cmd_nxt, r_upd_byte, r_err, w_key, w_map_cmd;
  logic [2:0] r_stat, w_stat_nxt, w_map_stat;
  logic w_event, w_frame_ok, w_valid, w_err, w_change;
  assign w_event = data_ready & ~r_dr_q;
  assign w_key = r_frame_q[23:16];
  // With the address check compiled out the custom-code compare folds away.
  assign w_frame_ok = r_frame_q[31:24] == ~w_key && (r_frame_q[15:0] == ADDR || !ADDR_CHECK);
  assign w_valid = r_chk_q & w_frame_ok;
  assign w_err = r_chk_q & ~w_frame_ok;
  assign w_map_stat = w_key == 8'h02 ? 3'd1 :
                      w_key == 8'h04 ? 3'd2 :
                      w_key == 8'h05 ? 3'd3 :
                      w_key == 8'h06 ? 3'd4 :
                      w_key == 8'h08 ? 3'd5 : 3'd0;
  assign w_map_cmd = w_key == 8'h02 ? 8'h02 :
                     w_key == 8'h04 ? 8'h08 :
                     w_key == 8'h05 ? 8'h10 :
                     w_key == 8'h06 ? 8'h20 :
                     w_key == 8'h08 ? 8'h80 : 8'h00;
  // A validated frame takes priority over an expiry on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt = r_cmd;
    w_stat_nxt = r_stat;
    w_timer_nxt = r_state == ACTIVE ? r_timer + 1'b1 : '0;
    if (w_valid) begin
      w_cmd_nxt = w_map_cmd;
      w_stat_nxt = w_map_stat;
      w_timer_nxt = '0;
      w_state_nxt = w_map_cmd != 8'h00 ? ACTIVE : IDLE;
    end else if (r_state == ACTIVE && r_timer == T_LAST) begin
      w_cmd_nxt = 8'h00;
      w_stat_nxt = 3'd0;
      w_timer_nxt = '0;
      w_state_nxt = IDLE;
    end
  end
  assign w_change = w_cmd_nxt != r_cmd;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dr_q <= 1'b0;
      r_chk_q <= 1'b0;
      r_frame_q <= '0;
      r_timer <= '0;
      r_cmd <= 8'h00;
      r_stat <= 3'd0;
      r_upd_valid <= 1'b0;
      r_upd_byte <= 8'h00;
      r_err <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_dr_q <= data_ready;
      r_chk_q <= w_event;
      if (w_event) r_frame_q <= ir_data;
      r_timer <= w_timer_nxt;
      r_cmd <= w_cmd_nxt;
      r_stat <= w_stat_nxt;
      // A change on the transfer cycle keeps valid high with the newer byte.
      r_upd_valid <= w_change | (r_upd_valid & ~upd_ready);
      if (w_change) r_upd_byte <= {4'b0000, w_stat_nxt, 1'b1};
      if (w_err) r_err <= r_err + {7'd0, r_err != 8'hFF};
    end
  end
  assign cmd = r_cmd;
  assign motor_stat = r_stat;
  assign upd_valid = r_upd_valid;
  assign upd_byte = r_upd_byte;
  assign err_count = r_err;
endmodule

// File: tb/tb_ir_cmd_decoder.sv
// tb_ir_cmd_decoder: directed checks of ir_cmd_decoder with a 20-cycle timeout
module tb_ir_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_ready = 1'b0;
  logic [31:0] ir_data = '0;
  logic upd_ready = 1'b1;
  logic [7:0] cmd, upd_byte, err_count;
  logic [2:0] motor_stat;
  logic upd_valid;
  int n_checks = 0;
  int n_fail = 0;
  int exp_err;
  ir_cmd_decoder #(.TIMEOUT_CYCLES(20), .ADDR(16'h7F80)) dut (
    .clk(clk),
    .rst(rst),
    .data_ready(data_ready),
    .ir_data(ir_data),
    .cmd(cmd),
    .motor_stat(motor_stat),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_byte(upd_byte),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Event cycle, capture edge, validate edge: returns just after cmd updates.
  task automatic send(input logic [31:0] d);
    tick;
    ir_data = d;
    data_ready = 1'b1;
    tick;
    data_ready = 1'b0;
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_cmd", cmd, 8'h00);
    chk("rst_stat", motor_stat, 3'd0);
    chk("rst_valid", upd_valid, 1'b0);
    chk("rst_byte", upd_byte, 8'h00);
    chk("rst_err", err_count, 8'h00);
    rst = 1'b0;
    tick;
    ir_data = 32'hFD02_7F80;
    data_ready = 1'b1;
    tick;
    data_ready = 1'b0;
    chk("lat_cmd_early", cmd, 8'h00);
    chk("lat_valid_early", upd_valid, 1'b0);
    tick;
    chk("fwd_cmd", cmd, 8'h02);
    chk("fwd_stat", motor_stat, 3'b001);
    chk("fwd_valid", upd_valid, 1'b1);
    chk("fwd_byte", upd_byte, 8'h03);
    tick;
    chk("fwd_valid_drop", upd_valid, 1'b0);
    send(32'hFC02_7F80);
    chk("bad_cmd", cmd, 8'h02);
    chk("bad_err", err_count, 8'h01);
    send(32'hFD02_7F80);
    chk("repeat_cmd", cmd, 8'h02);
    chk("repeat_no_upd", upd_valid, 1'b0);
    repeat (19) tick;
    chk("to_before", cmd, 8'h02);
    tick;
    chk("to_cmd", cmd, 8'h00);
    chk("to_stat", motor_stat, 3'd0);
    chk("to_valid", upd_valid, 1'b1);
    chk("to_byte", upd_byte, 8'h01);
    send(32'hFD02_7F80);
    chk("keep_first", cmd, 8'h02);
    for (int i = 0; i < 5; i++) begin
      repeat (12) tick;
      send(32'hFD02_7F80);
      chk("keep_cmd", cmd, 8'h02);
      chk("keep_no_upd", upd_valid, 1'b0);
    end
    repeat (20) tick;
    chk("keep_expire", cmd, 8'h00);
    tick;
    upd_ready = 1'b0;
    send(32'hFD02_7F80);
    send(32'hFB04_7F80);
    chk("stall_left", cmd, 8'h08);
    send(32'hF906_7F80);
    chk("stall_cmd", cmd, 8'h20);
    chk("stall_valid", upd_valid, 1'b1);
    chk("stall_byte", upd_byte, 8'h09);
    tick;
    tick;
    chk("stall_hold", upd_valid, 1'b1);
    chk("stall_hold_byte", upd_byte, 8'h09);
    upd_ready = 1'b1;
    chk("xfer_valid", upd_valid, 1'b1);
    tick;
    chk("xfer_drop", upd_valid, 1'b0);
    send(32'hFA05_7F80);
    chk("brake_cmd", cmd, 8'h10);
    chk("brake_byte", upd_byte, 8'h07);
    repeat (17) tick;
    chk("exp_pre", cmd, 8'h10);
    send(32'hF708_7F80);
    chk("exp_cmd", cmd, 8'h80);
    chk("exp_stat", motor_stat, 3'b101);
    chk("exp_valid", upd_valid, 1'b1);
    chk("exp_byte", upd_byte, 8'h0B);
    tick;
    chk("exp_after", cmd, 8'h80);
    repeat (25) tick;
    chk("bwd_timeout", cmd, 8'h00);
    exp_err = 1;
    send(32'hF708_1234);
`ifdef IR_ADDR_CHECK_EN
    chk("addr_reject", cmd, 8'h00);
    exp_err = 2;
`else
    chk("addr_ignored", cmd, 8'h80);
`endif
    chk("addr_err", err_count, exp_err);
    send(32'hF708_7F80);
    chk("addr_ok", cmd, 8'h80);
    repeat (10) send(32'hFC02_7F80);
    chk("err_count10", err_count, exp_err + 10);
    repeat (300) send(32'hFC02_7F80);
    chk("err_sat", err_count, 8'hFF);
    upd_ready = 1'b0;
    send(32'hFD02_7F80);
    chk("mid_valid", upd_valid, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_cmd", cmd, 8'h00);
    chk("mid_rst_stat", motor_stat, 3'd0);
    chk("mid_rst_valid", upd_valid, 1'b0);
    chk("mid_rst_byte", upd_byte, 8'h00);
    chk("mid_rst_err", err_count, 8'h00);
    upd_ready = 1'b1;
    send(32'hFD02_7F80);
    chk("post_rst_fwd", cmd, 8'h02);
    send(32'hFC03_7F80);
    chk("unmapped_cmd", cmd, 8'h00);
    chk("unmapped_valid", upd_valid, 1'b1);
    chk("unmapped_byte", upd_byte, 8'h01);
    chk("unmapped_err", err_count, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_cmd_decoder.md
# ir_cmd_decoder

Converts raw 32-bit NEC frames from the IR receiver into a registered one-hot drive command for the motor controller, with frame validation, a dead-man timeout that forces stop when the remote goes quiet, and a valid/ready update channel that feeds the UART status path. Sits between `IR_RECEIVE` (upstream, 50 MHz domain) and `Motor_ctrl_redone` / `uart_tx` (downstream).

## Interface
- `TIMEOUT_CYCLES`, 12_500_000, cycles with no accepted frame before the command reverts to stop (250 ms at 50 MHz); must be ≥ 2.
- `ADDR`, 16'h7F80, expected NEC custom code; used only with `IR_ADDR_CHECK_EN`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `data_ready`  in  1  level from IR receiver; a new frame is signalled by a 0→1 transition.
- `ir_data`  in  32  decoded frame: [31:24] inverted key, [23:16] key, [15:0] custom code; stable while `data_ready` is high.
- `cmd`  out  8  one-hot command to motor controller.
- `motor_stat`  out  3  encoded command for status byte.
- `upd_valid`  out  1  update available.
- `upd_ready`  in  1  consumer accepts the update.
- `upd_byte`  out  8  `{4'b0000, motor_stat, 1'b1}` captured at the change.
- `err_count`  out  8  saturating count of rejected frames.

## Operation
- Edge detect: `dr_q` registers `data_ready`; a frame event is `data_ready & ~dr_q`. Events while `rst` is high are discarded.
- Capture stage: on an event, `ir_data` is latched into `frame_q`; `chk_q` is set for one cycle.
- Validate stage (when `chk_q`): a frame is valid iff `frame_q[31:24] == ~frame_q[23:16]` (and the address matches, see Configuration). An invalid frame leaves `cmd` unchanged and increments `err_count` (saturates at 8'hFF, no wrap).
- Key map for valid frames (key → `cmd` / `motor_stat`): 0x02 → 8'h02/3'b001 forward; 0x04 → 8'h08/3'b010 left; 0x05 → 8'h10/3'b011 brake; 0x06 → 8'h20/3'b100 right; 0x08 → 8'h80/3'b101 backward; any other key → 8'h00/3'b000 stop. An unmapped key is still a valid frame (restarts timeout, not an error).
- States: IDLE (`cmd` = 0x00, timer held at 0) and ACTIVE (`cmd` ≠ 0x00, timer running). A valid mapped frame moves IDLE→ACTIVE or re-enters ACTIVE with the timer cleared. A valid stop/unmapped frame or a timeout moves to IDLE.
- Timeout: in ACTIVE the counter increments every cycle; when it reaches `TIMEOUT_CYCLES-1` the next edge sets `cmd` = 0x00, `motor_stat` = 0. A validated frame on that same cycle wins: command applied, counter cleared.
- Repeats of the same key restart the timer and do not generate an update.
- Update channel: any cycle where `cmd` changes value sets `upd_valid` and loads `upd_byte`. Transfer occurs on a cycle with `upd_valid & upd_ready`; `upd_valid` drops next cycle unless another change occurs on the transfer cycle, in which case it stays high with the new byte. While stalled, a further change overwrites `upd_byte` (latest wins; intermediate values are dropped).

## Timing
- Reset values: `cmd` 0x00, `motor_stat` 0, `upd_valid` 0, `upd_byte` 0x00, `err_count` 0, `dr_q` 0, timer 0, state IDLE.
- Latency: event sampled at edge N → `frame_q` at N+1 → `cmd`/`motor_stat`/`upd_valid` at N+2.
- Minimum spacing between accepted events: 3 cycles (faster edges are undefined; the receiver never produces them).
- `rst` asserted mid-frame or mid-handshake: all state returns to reset values on the next edge; the pending update is dropped.
- Timeout-to-stop asserts `upd_valid` on the same edge that clears `cmd`.

## Configuration
- `IR_ADDR_CHECK_EN` defined: a frame is valid only if `frame_q[15:0] == ADDR`; a mismatch counts as an error.
- Not defined: `frame_q[15:0]` is ignored and `ADDR` is unused.

## Test plan
- Reset, then frame 32'hFD02_7F80 → `cmd` = 0x02, `motor_stat` = 001, `upd_valid` high with `upd_byte` = 8'h03 exactly two cycles after the event.
- Frame 32'hFC02_7F80 (bad inverse) → `cmd` unchanged, `err_count` +1; 300 bad frames → `err_count` = 0xFF.
- `TIMEOUT_CYCLES` = 20, forward frame then silence → `cmd` = 0x00 exactly 20 cycles after the frame is applied, `upd_byte` = 8'h01; repeated forward frames every 15 cycles → never times out, no extra updates.
- Hold `upd_ready` low, send forward then left then right → single pending update with `upd_byte` = 8'h09; raise `upd_ready` → one transfer, `upd_valid` low next cycle.
- Frame validated on the expiry cycle → new command applied, no stop glitch on `cmd`.
- With `IR_ADDR_CHECK_EN`, frame 32'hF708_1234 → rejected, `err_count` +1; same key with custom code 16'h7F80 → `cmd` = 0x80.
